// File: rtl/actuator_bank.sv
`timescale 1ns/1ps
// actuator_bank: NUM_CH actuator outputs configured through one serial shift chain.
// A commit strobe moves the chain contents into the active mode/data registers.
module actuator_bank #(
    parameter int NUM_CH    = 4,
    parameter int DATA_WD   = 8,
    parameter int MODE_WD   = 3,
    parameter int FAST_DIV  = 1,
    parameter int SLOW_DIV  = 12,
    parameter int PULSE_DIV = 1000
) (
    input  logic              masterClk,
    input  logic              reset,
    input  logic              serialIn,
    input  logic              serialClk,
    input  logic              enableShift,
    input  logic              commit,
    input  logic              disableAll,
    output logic [NUM_CH-1:0] actuator,
    output logic              serialOut
);
    localparam int CHAIN_LEN = NUM_CH * (MODE_WD + DATA_WD);
    localparam int MAX_DIV   = (FAST_DIV > SLOW_DIV)
                               ? ((FAST_DIV > PULSE_DIV) ? FAST_DIV : PULSE_DIV)
                               : ((SLOW_DIV > PULSE_DIV) ? SLOW_DIV : PULSE_DIV);
    localparam int PRESC_WD  = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [MODE_WD-1:0] MODE_LOW       = MODE_WD'(0);
    localparam logic [MODE_WD-1:0] MODE_HIGH      = MODE_WD'(1);
    localparam logic [MODE_WD-1:0] MODE_PWM_FAST  = MODE_WD'(2);
    localparam logic [MODE_WD-1:0] MODE_PWM_SLOW  = MODE_WD'(3);
    localparam logic [MODE_WD-1:0] MODE_PULSE     = MODE_WD'(4);
    localparam logic [MODE_WD-1:0] MODE_PULSE_INV = MODE_WD'(5);
    localparam logic [MODE_WD-1:0] MODE_BLINK     = MODE_WD'(6);
    localparam logic [MODE_WD-1:0] MODE_RESERVED  = MODE_WD'(7);

    // ------------------------------------------------------------------
    // Free-running prescalers: index 0 fast, 1 slow, 2 pulse/blink
    // ------------------------------------------------------------------
    logic [2:0] tickVec;
    logic       fastTick;
    logic       slowTick;
    logic       pulseTick;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_presc
            localparam int DIV_I = (gi == 0) ? FAST_DIV : ((gi == 1) ? SLOW_DIV : PULSE_DIV);
            localparam logic [PRESC_WD-1:0] LAST = PRESC_WD'(DIV_I - 1);
            logic [PRESC_WD-1:0] cntReg;

            always_ff @(posedge masterClk or posedge reset) begin
                if (reset) begin
                    cntReg <= '0;
                end else if (cntReg == LAST) begin
                    cntReg <= '0;
                end else begin
                    cntReg <= cntReg + PRESC_WD'(1);
                end
            end

            assign tickVec[gi] = (cntReg == LAST);
        end
    endgenerate

    assign fastTick  = tickVec[0];
    assign slowTick  = tickVec[1];
    assign pulseTick = tickVec[2];

    // ------------------------------------------------------------------
    // Shared PWM phases, so every channel's PWM edges line up
    // ------------------------------------------------------------------
    logic [DATA_WD-1:0] fastPhaseReg;
    logic [DATA_WD-1:0] fastPhaseNext;
    logic [DATA_WD-1:0] slowPhaseReg;
    logic [DATA_WD-1:0] slowPhaseNext;

    always_comb begin
        fastPhaseNext = fastPhaseReg;
        slowPhaseNext = slowPhaseReg;
        if (fastTick) begin
            fastPhaseNext = fastPhaseReg + DATA_WD'(1);
        end
        if (slowTick) begin
            slowPhaseNext = slowPhaseReg + DATA_WD'(1);
        end
    end

    always_ff @(posedge masterClk or posedge reset) begin
        if (reset) begin
            fastPhaseReg <= '0;
            slowPhaseReg <= '0;
        end else begin
            fastPhaseReg <= fastPhaseNext;
            slowPhaseReg <= slowPhaseNext;
        end
    end

    // ------------------------------------------------------------------
    // Serial configuration chain
    // ------------------------------------------------------------------
    logic [CHAIN_LEN-1:0] shiftReg;
    logic                 prevSerialClkReg;
    logic                 shiftEn;
    logic                 commitAccept;

    assign shiftEn      = serialClk & ~prevSerialClkReg & enableShift;
    assign commitAccept = commit & ~enableShift & ~disableAll;
    assign serialOut    = shiftReg[CHAIN_LEN-1];

    always_ff @(posedge masterClk or posedge reset) begin
        if (reset) begin
            shiftReg         <= '0;
            prevSerialClkReg <= 1'b0;
        end else begin
            prevSerialClkReg <= serialClk;
            if (shiftEn) begin
                shiftReg <= {shiftReg[CHAIN_LEN-2:0], serialIn};
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel active configuration and pulse/blink state
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] chOut;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [MODE_WD-1:0] srMode;
            logic [DATA_WD-1:0] srData;
            logic [MODE_WD-1:0] modeReg;
            logic [MODE_WD-1:0] modeNext;
            logic [DATA_WD-1:0] dataReg;
            logic [DATA_WD-1:0] dataNext;
            logic [DATA_WD-1:0] cntReg;
            logic [DATA_WD-1:0] cntNext;
            // pulse modes: pulse still running; blink: current output level
            logic               flagReg;
            logic               flagNext;
            logic               outNext;

            assign srMode = shiftReg[CHAIN_LEN-1-gi*MODE_WD -: MODE_WD];
            assign srData = shiftReg[NUM_CH*DATA_WD-1-gi*DATA_WD -: DATA_WD];

            always_comb begin
                modeNext = modeReg;
                dataNext = dataReg;
                cntNext  = cntReg;
                flagNext = flagReg;
                if (commitAccept) begin
                    // A tick coinciding with the commit is deliberately not counted.
                    modeNext = srMode;
                    dataNext = srData;
                    cntNext  = srData;
                    flagNext = (srMode == MODE_BLINK) ? 1'b1 : (srData != '0);
                end else if (pulseTick) begin
                    case (modeReg)
                        MODE_PULSE, MODE_PULSE_INV: begin
                            if (flagReg) begin
                                if (cntReg <= DATA_WD'(1)) begin
                                    flagNext = 1'b0;
                                    cntNext  = '0;
                                end else begin
                                    cntNext = cntReg - DATA_WD'(1);
                                end
                            end
                        end
                        MODE_BLINK: begin
                            if (dataReg != '0) begin
                                if (cntReg <= DATA_WD'(1)) begin
                                    cntNext  = dataReg;
                                    flagNext = ~flagReg;
                                end else begin
                                    cntNext = cntReg - DATA_WD'(1);
                                end
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            // Output is derived from next-state values so the flop tracks the state one-for-one.
            always_comb begin
                outNext = 1'b0;
                case (modeNext)
                    MODE_LOW, MODE_RESERVED: outNext = 1'b0;
                    MODE_HIGH:               outNext = 1'b1;
                    MODE_PWM_FAST:           outNext = (fastPhaseNext < dataNext);
                    MODE_PWM_SLOW:           outNext = (slowPhaseNext < dataNext);
                    MODE_PULSE:              outNext = flagNext;
                    MODE_PULSE_INV:          outNext = ~flagNext;
                    MODE_BLINK:              outNext = flagNext & (dataNext != '0);
                    default:                 outNext = 1'b0;
                endcase
            end

            always_ff @(posedge masterClk or posedge reset) begin
                if (reset) begin
                    modeReg <= '0;
                    dataReg <= '0;
                    cntReg  <= '0;
                    flagReg <= 1'b0;
                end else begin
                    modeReg <= modeNext;
                    dataReg <= dataNext;
                    cntReg  <= cntNext;
                    flagReg <= flagNext;
                end
            end

            assign chOut[gi] = outNext;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Output register; disable masks outputs while all state keeps running
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] actuatorReg;

    always_ff @(posedge masterClk or posedge reset) begin
        if (reset) begin
            actuatorReg <= '0;
        end else if (disableAll) begin
            actuatorReg <= '0;
        end else begin
            actuatorReg <= chOut;
        end
    end

    assign actuator = actuatorReg;

endmodule

// File: doc/actuator_bank.md
Name: actuator_bank

Overview:
- Parametrised successor to the fixed 4-channel actuator chain. Generic bank of NUM_CH actuator outputs, configured by a single serial shift chain.
- Each channel has a configurable data width. A dedicated commit strobe separates shifting from activation.
- Adds a BLINK mode and defined safe-state behaviour.
- Sits between the ws2811 decoder/command logic (upstream) and the sensor chain (downstream, via serialOut).

Parameters:
- NUM_CH, 4: number of actuator channels (1..16).
- DATA_WD, 8: per-channel data field width (4..12).
- MODE_WD, 3: per-channel mode field width (fixed encoding uses 3).
- FAST_DIV, 1: masterClk cycles per fast-PWM tick (>=1).
- SLOW_DIV, 12: masterClk cycles per slow-PWM tick (>=1).
- PULSE_DIV, 1000: masterClk cycles per pulse/blink tick (>=1).

Ports:
- masterClk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- serialIn, in, 1: serial configuration data.
- serialClk, in, 1: serial bit clock, masterClk-synchronous level; rising edge detected internally.
- enableShift, in, 1: shift window; bits accepted only while high.
- commit, in, 1: one-cycle strobe; transfers the shift chain to the active configuration.
- disable, in, 1: safe state; forces all outputs low while high.
- actuator, out, NUM_CH: registered actuator outputs.
- serialOut, out, 1: MSB of the shift chain, feeds the downstream chain.

Behaviour:
- Reset (async, active-high): shift chain = 0, active mode/data regs = 0 (LOW), all counters = 0, prevSerialClk = 0, actuator = 0.
- Chain length: L = NUM_CH*(MODE_WD+DATA_WD).
- Shift condition: serialClk=1 & prevSerialClk=0 & enableShift=1.
  - On the shift condition: SR <= {SR[L-2:0], serialIn}.
  - serialOut = SR[L-1], combinational from the register.
  - Without enableShift, serialClk edges are ignored.
- Field layout after L shifts (first bit shifted in lands at SR[L-1]):
  - mode[i] = SR[L-1-i*MODE_WD -: MODE_WD].
  - data[i] = SR[NUM_CH*DATA_WD-1-i*DATA_WD -: DATA_WD].
  - Channel 0 is first in each group.
- Commit: accepted only when commit=1 & enableShift=0 & disable=0.
  - On acceptance, active mode/data regs load from SR, and the pulse/blink state of each channel is re-armed.
  - actuator reflects the new configuration on the following cycle (1-cycle latency).
  - A commit strobe while enableShift=1 or disable=1 is dropped; it is not queued.
- Shared tick prescalers:
  - Fast, slow and pulse tick counters run freely from reset; each tick is a 1-cycle strobe every *_DIV cycles.
  - Fast and slow phase counters (DATA_WD bits, wrap at 2^DATA_WD) advance on their own ticks.
  - All channels share the same phase, so PWM edges are aligned.
- Mode encoding per channel:
  - 0 LOW: output 0.
  - 1 HIGH: output 1.
  - 2 PWM_FAST: output = (fastPhase < data).
    - data=0 → constant 0.
    - data=max → high for (2^DATA_WD - 1) of every 2^DATA_WD ticks.
  - 3 PWM_SLOW: same rule using slowPhase.
  - 4 PULSE: on commit with data != 0, output goes 1 for exactly data pulse ticks, then 0.
    - The count starts at the first pulse tick after commit.
    - data=0 → constant 0.
  - 5 PULSE_INV: complement of PULSE. Idle level 1; data=0 → constant 1.
  - 6 BLINK: output starts at 1 on commit and toggles every data pulse ticks, indefinitely.
    - data=0 → constant 0.
  - 7 reserved: behaves as LOW.
- Re-commit while a pulse or blink is in progress restarts it with the new data. A commit with an unchanged configuration also restarts it.
- disable=1:
  - All outputs go 0 on the next cycle, including PULSE_INV and HIGH.
  - Active regs and counters keep running.
  - Pulse counters continue, so a pulse that expires under disable is not replayed.
  - On deassertion, outputs resume from current state on the next cycle.
- Simultaneous events:
  - A shift and an accepted commit cannot coincide, because commit requires enableShift=0.
  - A tick in the same cycle as commit is not counted toward the new pulse/blink.
  - Reset dominates everything.
- Width rules:
  - Pulse/blink counters are DATA_WD bits.
  - Prescaler counters are clog2(max DIV) bits.
  - No overflow is possible.

Test Plan:
- Reset then idle: assert reset mid-frame after 10 shifts → actuator=0000, serialOut=0; a commit with all-zero SR keeps 0000.
- Serial load, NUM_CH=4, DATA_WD=8: shift 44 bits with modes {HIGH,LOW,HIGH,LOW} and data 0x00, then commit → actuator=0101 exactly 1 cycle after commit. Commit while enableShift=1 → no change.
- PWM: ch0 PWM_FAST, data=0x40, FAST_DIV=1 → high 64 of every 256 cycles. data=0x00 → always 0. data=0xFF → low exactly 1 cycle per 256.
- Pulse, PULSE_DIV=4:
  - ch1 PULSE, data=3 → high for 12 cycles, then 0.
  - Re-commit with data=2 at cycle 5 → pulse restarts for 8 cycles.
  - PULSE_INV, data=0 → constant 1.
- Blink, PULSE_DIV=2: ch2 BLINK, data=5 → square wave with 10-cycle half-period starting high; mode 7 → constant 0.
- Disable: all channels HIGH, assert disable for 20 cycles → 0000 next cycle, 1111 one cycle after release. A commit during disable is dropped, and the old configuration persists.
